fb_access_arbiter: RTL and testbench

- Owns the single-port CHIP-8 framebuffer RAM: FB_ROWS words, each FB_COLS bits wide, one word per display row.
- Shares the RAM between two requesters:
  - the VGA scanout fetcher, which reads one row per request;
  - the CPU draw/clear unit, which issues sprite-row XOR read-modify-write and full-screen clear.
- VGA fetch always has priority. The CPU side uses a valid/ready handshake and gets a done pulse with the collision result.

---
 rtl/fb_pkg.sv | 19 +
 rtl/fb_access_arbiter_sprite_mask.sv | 38 +++
 rtl/fb_access_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fb_access_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants for the CHIP-8 framebuffer arbiter: geometry, op codes, FSM states.
package fb_pkg;

    localparam int unsigned FB_COLS_DEF = 64;
    localparam int unsigned FB_ROWS_DEF = 32;
    localparam int unsigned FB_COL_W    = $clog2(FB_COLS_DEF);
    localparam int unsigned FB_ROW_W    = $clog2(FB_ROWS_DEF);

    localparam logic OP_XOR = 1'b0;
    localparam logic OP_CLR = 1'b1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] VGA_WAIT = 3'd1;
    localparam logic [2:0] XR_RD    = 3'd2;
    localparam logic [2:0] XR_WAIT  = 3'd3;
    localparam logic [2:0] XR_WR    = 3'd4;
    localparam logic [2:0] CLR      = 3'd5;

endpackage

// File: rtl/fb_access_arbiter_sprite_mask.sv
// Places an 8-pixel sprite byte into a framebuffer row at column x.
// Macro FB_CLIP_EN: drop pixels past the right edge instead of wrapping.
module fb_sprite_mask #(
    parameter int unsigned FB_COLS = 64,
    localparam int unsigned COL_W  = $clog2(FB_COLS)
) (
    input  logic [COL_W-1:0]   x,
    input  logic [7:0]         sprite,
    output logic [FB_COLS-1:0] mask
);

`ifdef FB_CLIP_EN
    always_comb begin
        logic [COL_W:0] col;
        col  = '0;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            col = (COL_W+1)'(x) + (COL_W+1)'(i);
            // carry out means the pixel lies beyond column FB_COLS-1
            if (!col[COL_W]) begin
                mask[col[COL_W-1:0]] = mask[col[COL_W-1:0]] | sprite[3'(7 - i)];
            end
        end
    end
`else
    always_comb begin
        logic [COL_W-1:0] col;
        col  = '0;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            // natural COL_W-bit overflow wraps to column 0
            col = x + COL_W'(i);
            mask[col] = mask[col] | sprite[3'(7 - i)];
        end
    end
`endif

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer owner: VGA row fetch (priority) vs CPU sprite XOR / clear.
// Optional macro FB_CLIP_EN (in fb_sprite_mask) clips sprites at the right edge.
module fb_access_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned FB_COLS = FB_COLS_DEF,
    parameter int unsigned FB_ROWS = FB_ROWS_DEF,
    localparam int unsigned COL_W  = $clog2(FB_COLS),
    localparam int unsigned ROW_W  = $clog2(FB_ROWS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vga_req,
    input  logic [ROW_W-1:0]   vga_row,
    output logic [FB_COLS-1:0] vga_row_data,
    output logic               vga_row_valid,
    output logic               vga_overrun,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [COL_W-1:0]   cmd_x,
    input  logic [ROW_W-1:0]   cmd_y,
    input  logic [7:0]         cmd_byte,
    output logic               cmd_done,
    output logic               cmd_collision,
    output logic [ROW_W-1:0]   ram_addr,
    output logic               ram_we,
    output logic [FB_COLS-1:0] ram_wdata,
    input  logic [FB_COLS-1:0] ram_rdata
);

    logic [2:0]         state, state_d;
    logic [2:0]         resume_state, resume_d;
    logic               vga_pend;
    logic [ROW_W-1:0]   vga_pend_row;
    logic [COL_W-1:0]   cmd_x_q;
    logic [ROW_W-1:0]   cmd_y_q;
    logic [7:0]         cmd_byte_q;
    logic [ROW_W-1:0]   clr_row;
    logic [FB_COLS-1:0] xr_new;
    logic               xr_coll;
    logic [FB_COLS-1:0] mask;

    logic fetch_go, accept, xr_load, xr_commit, clr_step, clr_last;

    fb_sprite_mask #(.FB_COLS(FB_COLS)) u_mask (
        .x      (cmd_x_q),
        .sprite (cmd_byte_q),
        .mask   (mask)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            resume_state <= IDLE;
        end else begin
            state        <= state_d;
            resume_state <= resume_d;
        end
    end

    // Next state plus the RAM port, which is a decode of the registered state
    // so a row address reaches the RAM in the same cycle the decision is made.
    always_comb begin
        state_d   = state;
        resume_d  = resume_state;
        fetch_go  = 1'b0;
        accept    = 1'b0;
        xr_load   = 1'b0;
        xr_commit = 1'b0;
        clr_step  = 1'b0;
        clr_last  = 1'b0;
        cmd_ready = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (state)
            IDLE: begin
                if (vga_pend) begin
                    ram_addr = vga_pend_row;
                    fetch_go = 1'b1;
                    resume_d = IDLE;
                    state_d  = VGA_WAIT;
                end else begin
                    // a same-cycle VGA request wins the slot
                    cmd_ready = !vga_req;
                    if (cmd_valid && !vga_req) begin
                        accept  = 1'b1;
                        state_d = (cmd_op == OP_XOR) ? XR_RD : CLR;
                    end
                end
            end
            VGA_WAIT: state_d = resume_state;
            XR_RD: begin
                ram_addr = cmd_y_q;
                state_d  = XR_WAIT;
            end
            XR_WAIT: begin
                xr_load = 1'b1;
                state_d = XR_WR;
            end
            XR_WR: begin
                ram_addr  = cmd_y_q;
                ram_we    = 1'b1;
                ram_wdata = xr_new;
                xr_commit = 1'b1;
                state_d   = IDLE;
            end
            CLR: begin
                if (vga_pend) begin
                    ram_addr = vga_pend_row;
                    fetch_go = 1'b1;
                    resume_d = CLR;
                    state_d  = VGA_WAIT;
                end else begin
                    ram_addr = clr_row;
                    ram_we   = 1'b1;
                    clr_step = 1'b1;
                    if (clr_row == ROW_W'(FB_ROWS - 1)) begin
                        clr_last = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            cmd_ready = 1'b0;
            ram_addr  = '0;
            ram_we    = 1'b0;
            ram_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_pend      <= 1'b0;
            vga_pend_row  <= '0;
            vga_overrun   <= 1'b0;
            vga_row_valid <= 1'b0;
            vga_row_data  <= '0;
            cmd_x_q       <= '0;
            cmd_y_q       <= '0;
            cmd_byte_q    <= '0;
            clr_row       <= '0;
            xr_new        <= '0;
            xr_coll       <= 1'b0;
            cmd_done      <= 1'b0;
            cmd_collision <= 1'b0;
        end else begin
            // a fresh request overrides the clear of an issued fetch
            if (vga_req) begin
                vga_pend     <= 1'b1;
                vga_pend_row <= vga_row;
            end else if (fetch_go) begin
                vga_pend <= 1'b0;
            end
            if (vga_req && vga_pend) begin
                vga_overrun <= 1'b1;
            end
            vga_row_valid <= (state == VGA_WAIT);
            if (state == VGA_WAIT) begin
                vga_row_data <= ram_rdata;
            end
            if (accept) begin
                cmd_x_q    <= cmd_x;
                cmd_y_q    <= cmd_y;
                cmd_byte_q <= cmd_byte;
                clr_row    <= '0;
            end
            if (xr_load) begin
                xr_new  <= ram_rdata ^ mask;
                xr_coll <= |(ram_rdata & mask);
            end
            if (clr_step) begin
                clr_row <= clr_row + ROW_W'(1);
            end
            cmd_done      <= xr_commit || clr_last;
            cmd_collision <= xr_commit && xr_coll;
        end
    end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a behavioural single-port RAM.
module tb_fb_access_arbiter;
    import fb_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                vga_req;
    logic [FB_ROW_W-1:0] vga_row;
    logic [63:0]         vga_row_data;
    logic                vga_row_valid;
    logic                vga_overrun;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_op;
    logic [FB_COL_W-1:0] cmd_x;
    logic [FB_ROW_W-1:0] cmd_y;
    logic [7:0]          cmd_byte;
    logic                cmd_done;
    logic                cmd_collision;
    logic [FB_ROW_W-1:0] ram_addr;
    logic                ram_we;
    logic [63:0]         ram_wdata;
    logic [63:0]         ram_rdata;

    logic [63:0]         mem [32];
    logic                tb_we;
    logic [4:0]          tb_addr;
    logic [63:0]         tb_wdata;
    int                  we_cnt;
    int                  done_cnt;
    int                  checks;
    int                  failures;

    typedef struct {
        logic [4:0]  y;
        logic [5:0]  x;
        logic [7:0]  b;
        logic [63:0] pre;
        logic [63:0] exp_row;
        logic        exp_coll;
    } xor_vec_t;

    xor_vec_t vecs [6];

    fb_access_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vga_req       (vga_req),
        .vga_row       (vga_row),
        .vga_row_data  (vga_row_data),
        .vga_row_valid (vga_row_valid),
        .vga_overrun   (vga_overrun),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_x         (cmd_x),
        .cmd_y         (cmd_y),
        .cmd_byte      (cmd_byte),
        .cmd_done      (cmd_done),
        .cmd_collision (cmd_collision),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // synchronous-read RAM; the bench preload port takes precedence
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_wdata;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        we_cnt   = 0;
        done_cnt = 0;
    end

    always @(posedge clk) begin
        if (ram_we) we_cnt <= we_cnt + 1;
        if (cmd_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [4:0] addr, input logic [63:0] data);
        @(negedge clk);
        tb_we    = 1'b1;
        tb_addr  = addr;
        tb_wdata = data;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic do_cmd(input logic op, input logic [5:0] x, input logic [4:0] y,
                          input logic [7:0] b, output int lat, output logic coll);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_byte  = b;
        #1;
        chk("cmd_ready_on_accept", 64'(cmd_ready), 64'd1);
        lat  = 0;
        coll = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_x     = ~x;
            cmd_y     = ~y;
            cmd_byte  = ~b;
            #1;
            if (cmd_done) begin
                lat  = k;
                coll = cmd_collision;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic        coll;
        int          we0;
        int          d0;
        int          vga_at;
        int          vga_n;
        int          acc_at;
        int          done_at;
        logic [63:0] vdata;
        int          nonzero;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        vga_req   = 1'b0;
        vga_row   = '0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_byte  = '0;
        tb_we     = 1'b0;
        tb_addr   = '0;
        tb_wdata  = '0;

`ifdef FB_CLIP_EN
        vecs[2] = '{y: 5'd3,  x: 6'd60, b: 8'hFF, pre: 64'h0, exp_row: 64'hF000_0000_0000_0000, exp_coll: 1'b0};
        vecs[4] = '{y: 5'd31, x: 6'd62, b: 8'hC3, pre: '1,    exp_row: 64'h3FFF_FFFF_FFFF_FFFF, exp_coll: 1'b1};
`else
        vecs[2] = '{y: 5'd3,  x: 6'd60, b: 8'hFF, pre: 64'h0, exp_row: 64'hF000_0000_0000_000F, exp_coll: 1'b0};
        vecs[4] = '{y: 5'd31, x: 6'd62, b: 8'hC3, pre: '1,    exp_row: 64'h3FFF_FFFF_FFFF_FFCF, exp_coll: 1'b1};
`endif
        vecs[0] = '{y: 5'd0,  x: 6'd0,  b: 8'hA5, pre: 64'h0,   exp_row: 64'h0000_0000_0000_00A5, exp_coll: 1'b0};
        vecs[1] = '{y: 5'd0,  x: 6'd0,  b: 8'hA5, pre: 64'hA5,  exp_row: 64'h0,                   exp_coll: 1'b1};
        vecs[3] = '{y: 5'd7,  x: 6'd10, b: 8'h81, pre: 64'h0,   exp_row: 64'h0000_0000_0002_0400, exp_coll: 1'b0};
        vecs[5] = '{y: 5'd12, x: 6'd4,  b: 8'h3C, pre: 64'hF00, exp_row: 64'h0000_0000_0000_0CC0, exp_coll: 1'b1};

        // reset values, sampled while reset is still held
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_vga_valid", 64'(vga_row_valid), 64'd0);
        chk("rst_overrun", 64'(vga_overrun), 64'd0);
        chk("rst_cmd_done", 64'(cmd_done), 64'd0);
        chk("rst_collision", 64'(cmd_collision), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_wdata", ram_wdata, 64'd0);
        chk("rst_vga_data", vga_row_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle fetch: valid three cycles after the request, no write
        preload(5'd5, 64'hF0F0_0000_0000_000F);
        we0 = we_cnt;
        @(negedge clk);
        vga_req = 1'b1;
        vga_row = 5'd5;
        vga_at  = -1;
        vdata   = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            vga_req = 1'b0;
            #1;
            if (vga_row_valid && vga_at < 0) begin
                vga_at = k;
                vdata  = vga_row_data;
            end
        end
        chk("idle_fetch_latency", 64'(vga_at), 64'd3);
        chk("idle_fetch_data", vdata, 64'hF0F0_0000_0000_000F);
        chk("idle_fetch_no_write", 64'(we_cnt - we0), 64'd0);

        // table of XOR sprite rows
        foreach (vecs[i]) begin
            preload(vecs[i].y, vecs[i].pre);
            do_cmd(OP_XOR, vecs[i].x, vecs[i].y, vecs[i].b, lat, coll);
            chk($sformatf("xor%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("xor%0d_collision", i), 64'(coll), 64'(vecs[i].exp_coll));
            chk($sformatf("xor%0d_row", i), mem[vecs[i].y], vecs[i].exp_row);
        end

        // clear with a VGA fetch of an uncleared row in the middle
        for (int r = 0; r < 32; r++) preload(5'(r), '1);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_CLR;
        #1;
        chk("clr_ready", 64'(cmd_ready), 64'd1);
        vga_at  = -1;
        done_at = -1;
        vdata   = '0;
        coll    = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_op    = 1'b0;
            vga_req   = (k == 5);
            vga_row   = 5'd31;
            #1;
            if (vga_row_valid && vga_at < 0) begin
                vga_at = k;
                vdata  = vga_row_data;
            end
            if (cmd_done && done_at < 0) begin
                done_at = k;
                coll    = cmd_collision;
            end
        end
        nonzero = 0;
        for (int r = 0; r < 32; r++) if (mem[r] != 64'h0) nonzero++;
        chk("clr_fetch_cycle", 64'(vga_at), 64'd8);
        chk("clr_fetch_data", vdata, '1);
        chk("clr_done_latency", 64'(done_at), 64'd35);
        chk("clr_collision", 64'(coll), 64'd0);
        chk("clr_nonzero_rows", 64'(nonzero), 64'd0);

        // simultaneous vga_req and cmd_valid: VGA first, command held off
        preload(5'd7, 64'h1234_5678_9ABC_DEF0);
        preload(5'd9, 64'h0);
        @(negedge clk);
        vga_req   = 1'b1;
        vga_row   = 5'd7;
        cmd_valid = 1'b1;
        cmd_op    = OP_XOR;
        cmd_x     = 6'd8;
        cmd_y     = 5'd9;
        cmd_byte  = 8'hFF;
        acc_at    = -1;
        vga_at    = -1;
        done_at   = -1;
        vdata     = '0;
        #1;
        if (cmd_ready && cmd_valid) acc_at = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            vga_req = 1'b0;
            if (acc_at >= 0) cmd_valid = 1'b0;
            #1;
            if (cmd_ready && cmd_valid && acc_at < 0) acc_at = k;
            if (vga_row_valid && vga_at < 0) begin
                vga_at = k;
                vdata  = vga_row_data;
            end
            if (cmd_done && done_at < 0) done_at = k;
        end
        chk("cont_vga_cycle", 64'(vga_at), 64'd3);
        chk("cont_vga_data", vdata, 64'h1234_5678_9ABC_DEF0);
        chk("cont_accept_cycle", 64'(acc_at), 64'd3);
        chk("cont_done_cycle", 64'(done_at), 64'd7);
        chk("cont_row", mem[9], 64'h0000_0000_0000_FF00);

        // two requests back to back during an XOR: one fetch of the later row
        preload(5'd1, 64'h1111_1111_1111_1111);
        preload(5'd2, 64'h2222_3333_4444_5555);
        preload(5'd10, 64'h0);
        chk("pre_overrun", 64'(vga_overrun), 64'd0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_XOR;
        cmd_x     = 6'd0;
        cmd_y     = 5'd10;
        cmd_byte  = 8'h01;
        vga_at    = -1;
        vga_n     = 0;
        done_at   = -1;
        vdata     = '0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            vga_req   = (k == 1) || (k == 2);
            vga_row   = (k == 1) ? 5'd1 : 5'd2;
            #1;
            if (vga_row_valid) begin
                vga_n++;
                if (vga_at < 0) begin
                    vga_at = k;
                    vdata  = vga_row_data;
                end
            end
            if (cmd_done && done_at < 0) done_at = k;
        end
        chk("ovr_flag", 64'(vga_overrun), 64'd1);
        chk("ovr_fetch_count", 64'(vga_n), 64'd1);
        chk("ovr_fetch_cycle", 64'(vga_at), 64'd6);
        chk("ovr_fetch_data", vdata, 64'h2222_3333_4444_5555);
        chk("ovr_xor_done", 64'(done_at), 64'd4);
        chk("ovr_xor_row", mem[10], 64'h0000_0000_0000_0080);

        // reset during XR_WAIT aborts the read-modify-write
        preload(5'd20, 64'hDEAD_BEEF_0123_4567);
        we0 = we_cnt;
        d0  = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_XOR;
        cmd_x     = 6'd0;
        cmd_y     = 5'd20;
        cmd_byte  = 8'hFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_overrun", 64'(vga_overrun), 64'd0);
        chk("mid_rst_vga_data", vga_row_data, 64'd0);
        chk("mid_rst_vga_valid", 64'(vga_row_valid), 64'd0);
        chk("mid_rst_done", 64'(cmd_done), 64'd0);
        chk("mid_rst_ram_we", 64'(ram_we), 64'd0);
        chk("mid_rst_ram_addr", 64'(ram_addr), 64'd0);
        repeat (8) @(negedge clk);
        chk("mid_rst_no_write", 64'(we_cnt - we0), 64'd0);
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("mid_rst_row_kept", mem[20], 64'hDEAD_BEEF_0123_4567);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
